// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, memory-requester FSM states, default data-memory size.
package y86_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;
  localparam int unsigned ICODE_W           = 4;

  localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory request; expired_c flags the LIMIT-th enabled cycle.
module dmem_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds 0..LIMIT-1 while enabled, so the last enabled cycle is LIMIT-1.
  assign expired_c = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_requester.sv
// Y86 memory-stage initiator: one req/ack data-memory access per instruction.
// Optional request timeout is built in when DMEM_TIMEOUT_EN is defined.
module dmem_requester
  import y86_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = MEM_WORDS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   icode,
  input  logic [63:0]  valA,
  input  logic [63:0]  valE,
  input  logic [63:0]  valP,
  output logic         busy,
  output logic         done,
  output logic [63:0]  valM,
  output logic         dmem_error,
  output logic         mem_req,
  output logic         mem_we,
  output logic [63:0]  mem_addr,
  output logic [63:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [63:0]  mem_rdata
);

  localparam int unsigned DW = 64;

  dmem_state_e   state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          req_q, req_d, we_q, we_d;
  logic [DW-1:0] valm_q, valm_d, addr_q, addr_d, wdata_q, wdata_d;

  logic          dec_mem_c, dec_we_c, in_range_c, timeout_c;
  logic [DW-1:0] dec_addr_c, dec_wdata_c;

  // Instruction decode into access kind, address and store data.
  always_comb begin
    dec_mem_c   = 1'b1;
    dec_we_c    = 1'b0;
    dec_addr_c  = valE;
    dec_wdata_c = valA;
    case (icode)
      I_RMMOVQ, I_PUSHQ: dec_we_c = 1'b1;
      I_CALL: begin
        dec_we_c    = 1'b1;
        dec_wdata_c = valP;
      end
      I_MRMOVQ: dec_we_c = 1'b0;
      I_POPQ, I_RET: dec_addr_c = valA;
      default: dec_mem_c = 1'b0;
    endcase
  end

  assign in_range_c = dec_addr_c < DW'(MEM_WORDS);

`ifdef DMEM_TIMEOUT_EN
  logic to_clr_c, to_en_c;
  assign to_clr_c = (state_q != REQ);
  assign to_en_c  = (state_q == REQ);

  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (to_clr_c),
    .en        (to_en_c),
    .expired_c (timeout_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_c          = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    valm_d  = valm_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          we_d    = dec_we_c;
          addr_d  = dec_addr_c;
          wdata_d = dec_wdata_c;
          if (!dec_mem_c) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else if (!in_range_c) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A same-cycle ack beats the timeout.
        if (mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!we_q) valm_d = mem_rdata;
        end else if (timeout_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    req_d  = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      valm_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      valm_q  <= valm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dmem_error = err_q;
  assign valM       = valm_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Randomized bench for dmem_requester with a transaction-level timing/data model and a memory responder.
module tb_dmem_requester;

  localparam int unsigned MEMW = 1024;
  localparam int          TO   = 16;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_n, start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP, valM, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, dmem_error, mem_req, mem_we, mem_ack;

  dmem_requester #(.MEM_WORDS(MEMW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Current transaction as seen by the model, relative to its start cycle t0.
  int          t0 = -1000;
  bit          t_acc = 1'b0;
  int          t_req_last = 0;
  int          t_done_rel = 1;
  logic        t_we = 1'b0;
  logic        t_err = 1'b0;
  logic [63:0] t_addr = '0, t_wdata = '0;
  logic [63:0] vm_old = '0, vm_new = '0;
  bit          cmp_en = 1'b0;
  int          resp_d = 0;

  logic [63:0] model_mem [MEMW];
  logic [63:0] resp_mem  [MEMW];

  // Per-cycle compare of DUT outputs against the transaction model.
  always begin : cmp_p
    int rel;
    bit e_req, e_done, e_busy;
    @(posedge clk);
    #2;
    if (cmp_en && rst_n) begin
      rel    = cyc - t0;
      e_req  = t_acc && rel >= 1 && rel <= t_req_last;
      e_done = (rel == t_done_rel);
      e_busy = (rel >= 1) && (rel <= t_done_rel);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("mem_req", 64'(mem_req), 64'(e_req));
      chk("valM", valM, (rel >= t_done_rel) ? vm_new : vm_old);
      if (e_req) begin
        chk("mem_we", 64'(mem_we), 64'(t_we));
        chk("mem_addr", mem_addr, t_addr);
        if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
      end
      if (e_done) chk("dmem_error", 64'(dmem_error), 64'(t_err));
    end
  end

  // Responder: acks on the (resp_d+1)-th request cycle, with random ack/data noise outside REQ.
  int req_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      req_cnt = 0;
    end else if (mem_req) begin
      if (req_cnt == resp_d) begin
        mem_ack   = 1'b1;
        mem_rdata = resp_mem[mem_addr[9:0]];
        if (mem_we) resp_mem[mem_addr[9:0]] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      req_cnt++;
    end else begin
      req_cnt   = 0;
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom};
    end
  end

  int          ob_busy, ob_req_cnt, ob_req_rel, ob_done_rel;
  logic        ob_we, ob_err;
  logic [63:0] ob_addr, ob_wdata, ob_valm;

  task automatic run_txn(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input int d);
    bit          acc, we, got;
    logic [63:0] addr, wd;
    @(negedge clk);
    acc = 1'b1; we = 1'b0; addr = e; wd = a;
    case (ic)
      4'h4, 4'hA: we = 1'b1;
      4'h8: begin we = 1'b1; wd = p; end
      4'h5: we = 1'b0;
      4'h9, 4'hB: addr = a;
      default: acc = 1'b0;
    endcase
    vm_old = vm_new;
    t_we = we; t_addr = addr; t_wdata = wd;
    if (!acc) begin
      t_acc = 1'b0; t_req_last = 0; t_done_rel = 1; t_err = 1'b0;
    end else if (addr >= 64'(MEMW)) begin
      t_acc = 1'b0; t_req_last = 0; t_done_rel = 1; t_err = 1'b1;
    end else if (TO_EN && d >= TO) begin
      t_acc = 1'b1; t_req_last = TO; t_done_rel = TO + 1; t_err = 1'b1;
    end else begin
      t_acc = 1'b1; t_req_last = d + 1; t_done_rel = d + 2; t_err = 1'b0;
      if (we) model_mem[addr[9:0]] = wd;
      else    vm_new = model_mem[addr[9:0]];
    end
    icode = ic; valA = a; valE = e; valP = p; resp_d = d; start = 1'b1;
    t0 = cyc;
    ob_busy = 0; ob_req_cnt = 0; ob_req_rel = 0; ob_done_rel = 0; got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk);
      #3;
      start = 1'b0;
      icode = 4'($urandom); valA = {$urandom, $urandom}; valE = {$urandom, $urandom};
      if (busy) ob_busy++;
      if (mem_req) begin
        if (ob_req_cnt == 0) begin
          ob_req_rel = cyc - t0; ob_we = mem_we; ob_addr = mem_addr; ob_wdata = mem_wdata;
        end
        ob_req_cnt++;
      end
      if (done) begin
        ob_done_rel = cyc - t0; ob_err = dmem_error; ob_valm = valM; got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done within 60 cycles (icode %h)", ic);
    end
    @(posedge clk);
    #3;
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 64'($urandom_range(0, MEMW - 1));
    else if (r == 7) return 64'(MEMW + $urandom_range(0, 3));
    else if (r == 8) return {$urandom | 32'h1, $urandom};
    else             return '1;
  endfunction

  initial begin
    for (int i = 0; i < int'(MEMW); i++) begin
      model_mem[i] = {32'hC0DE_0000 + 32'(i), 32'(i) * 32'd7};
      resp_mem[i]  = model_mem[i];
    end
    rst_n = 1'b0; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", 64'(dmem_error), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_txn(4'h4, 64'd123, 64'd203, 64'd0, 0);
    chk("rmmovq_req_rel", 64'(ob_req_rel), 64'd1);
    chk("rmmovq_we", 64'(ob_we), 64'd1);
    chk("rmmovq_addr", ob_addr, 64'd203);
    chk("rmmovq_wdata", ob_wdata, 64'd123);
    chk("rmmovq_done_rel", 64'(ob_done_rel), 64'd2);
    chk("rmmovq_err", 64'(ob_err), 64'd0);

    run_txn(4'h5, 64'd0, 64'd203, 64'd0, 3);
    chk("mrmovq_busy_cycles", 64'(ob_busy), 64'd5);
    chk("mrmovq_valM", ob_valm, 64'd123);

    run_txn(4'hB, 64'd100, 64'd108, 64'd0, 1);
    chk("popq_addr", ob_addr, 64'd100);
    chk("popq_we", 64'(ob_we), 64'd0);

    run_txn(4'h8, 64'd5, 64'd96, 64'h40, 0);
    chk("call_addr", ob_addr, 64'd96);
    chk("call_wdata", ob_wdata, 64'h40);

    run_txn(4'h5, 64'd0, 64'd1024, 64'd0, 0);
    chk("oob_req_cnt", 64'(ob_req_cnt), 64'd0);
    chk("oob_done_rel", 64'(ob_done_rel), 64'd1);
    chk("oob_err", 64'(ob_err), 64'd1);

    run_txn(4'h6, 64'd1, 64'd2, 64'd3, 0);
    chk("opq_req_cnt", 64'(ob_req_cnt), 64'd0);
    chk("opq_done_rel", 64'(ob_done_rel), 64'd1);
    chk("opq_err", 64'(ob_err), 64'd0);

    run_txn(4'h9, '1, 64'd5, 64'd0, 0);
    chk("ret_allones_err", 64'(ob_err), 64'd1);

    // Reset asserted while the request is outstanding.
    @(negedge clk);
    vm_old = vm_new;
    t_acc = 1'b1; t_we = 1'b0; t_addr = 64'd300; t_req_last = 51; t_done_rel = 52; t_err = 1'b0;
    icode = 4'h5; valE = 64'd300; resp_d = 50; start = 1'b1; t0 = cyc;
    @(posedge clk); #3; start = 1'b0;
    repeat (2) begin @(posedge clk); #3; end
    chk("mid_req_high", 64'(mem_req), 64'd1);
    @(negedge clk);
    cmp_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    t0 = -1000; vm_old = '0; vm_new = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(4'h5, 64'd0, 64'd203, 64'd0, 2);
    chk("after_rst_valM", ob_valm, 64'd123);

    if (TO_EN) begin
      run_txn(4'h5, 64'd0, 64'd10, 64'd0, 30);
      chk("to_done_rel", 64'(ob_done_rel), 64'd17);
      chk("to_err", 64'(ob_err), 64'd1);
      run_txn(4'h5, 64'd0, 64'd11, 64'd0, 15);
      chk("to_ack16_done_rel", 64'(ob_done_rel), 64'd17);
      chk("to_ack16_err", 64'(ob_err), 64'd0);
    end else begin
      run_txn(4'h5, 64'd0, 64'd10, 64'd0, 20);
      chk("long_wait_done_rel", 64'(ob_done_rel), 64'd22);
      chk("long_wait_err", 64'(ob_err), 64'd0);
    end

    for (int n = 0; n < 150; n++) begin
      int d;
      d = (TO_EN && $urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18))
                                              : int'($urandom_range(0, 5));
      run_txn(4'($urandom_range(0, 15)), rand_addr(), rand_addr(), {$urandom, $urandom}, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
